// File: rtl/fetch_ifid_stage.sv
// MIPS instruction-fetch stage: PC, bench-loadable instruction memory and the IF/ID register.
// Define FETCH_EARLY_JUMP_EN to resolve J from IF/ID here and expose JumpTaken.
module fetch_ifid_stage #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        LoadEn,
  input  logic [31:0] LoadAddr,
  input  logic [31:0] LoadData,
  output logic [31:0] PC,
  output logic [31:0] IFIDPC,
  output logic [31:0] IFIDIR,
  output logic        IFIDValid
`ifdef FETCH_EARLY_JUMP_EN
  ,
  output logic        JumpTaken
`endif
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned HI = AW + 2;

  logic [31:0] imem [MEM_WORDS] = '{default: '0};

  logic [AW-1:0] fetch_idx;
  logic          fetch_hit;
  logic [31:0]   inst;
  logic [AW-1:0] load_idx;
  logic          load_hit;
  logic [31:0]   pc_plus4;
  logic          jump_c;
  logic [31:0]   jump_target;
  logic [31:0]   pc_next;
  logic [31:0]   ifidpc_next;
  logic [31:0]   ifidir_next;
  logic          ifidvalid_next;
  logic          unused_bits;

  // Addresses at or beyond the memory size fetch a nop instead of aliasing.
  assign fetch_idx = PC[HI-1:2];
  assign fetch_hit = (PC[31:HI] == '0);
  assign inst      = fetch_hit ? imem[fetch_idx] : 32'h0;
  assign pc_plus4  = PC + 32'd4;

  assign load_idx  = LoadAddr[HI-1:2];
  assign load_hit  = LoadEn && (LoadAddr[31:HI] == '0);

  assign unused_bits = ^{BranchTarget[1:0], LoadAddr[1:0]};

`ifdef FETCH_EARLY_JUMP_EN
  assign jump_c      = IFIDValid && (IFIDIR[31:26] == 6'b000010) && !PCSrc && !Stall;
  assign jump_target = {IFIDPC[31:28], IFIDIR[25:0], 2'b00};
  assign JumpTaken   = jump_c;
`else
  assign jump_c      = 1'b0;
  assign jump_target = 32'h0;
`endif

  // Write port is registered, so a store reaches the fetch path one cycle later.
  always_ff @(posedge Clk) begin
    if (load_hit) begin
      imem[load_idx] <= LoadData;
    end
  end

  // Redirect beats stall; stall freezes everything; otherwise advance sequentially.
  always_comb begin
    pc_next        = PC;
    ifidpc_next    = IFIDPC;
    ifidir_next    = IFIDIR;
    ifidvalid_next = IFIDValid;
    if (PCSrc) begin
      pc_next        = {BranchTarget[31:2], 2'b00};
      ifidpc_next    = 32'h0;
      ifidir_next    = 32'h0;
      ifidvalid_next = 1'b0;
    end else if (!Stall) begin
      if (jump_c) begin
        pc_next        = jump_target;
        ifidpc_next    = 32'h0;
        ifidir_next    = 32'h0;
        ifidvalid_next = 1'b0;
      end else begin
        pc_next        = pc_plus4;
        ifidpc_next    = pc_plus4;
        ifidir_next    = inst;
        ifidvalid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      PC        <= RESET_PC;
      IFIDPC    <= 32'h0;
      IFIDIR    <= 32'h0;
      IFIDValid <= 1'b0;
    end else begin
      PC        <= pc_next;
      IFIDPC    <= ifidpc_next;
      IFIDIR    <= ifidir_next;
      IFIDValid <= ifidvalid_next;
    end
  end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: reference model checked every negedge plus literal spot checks.
module tb_fetch_ifid_stage;

  localparam int unsigned MEM_WORDS = 256;
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        LoadEn = 1'b0;
  logic [31:0] LoadAddr = 32'h0;
  logic [31:0] LoadData = 32'h0;
  logic [31:0] PC;
  logic [31:0] IFIDPC;
  logic [31:0] IFIDIR;
  logic        IFIDValid;
`ifdef FETCH_EARLY_JUMP_EN
  logic        JumpTaken;
`endif

  fetch_ifid_stage #(.MEM_WORDS(MEM_WORDS), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .PC(PC), .IFIDPC(IFIDPC), .IFIDIR(IFIDIR), .IFIDValid(IFIDValid)
`ifdef FETCH_EARLY_JUMP_EN
    , .JumpTaken(JumpTaken)
`endif
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] mmem [MEM_WORDS];
  logic [31:0] m_pc, m_ifpc, m_ir;
  logic        m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_ifpc = 32'h0; m_ir = 32'h0; m_valid = 1'b0;
  endtask

  function automatic logic [31:0] m_fetch();
    if (m_pc < MEM_BYTES) return mmem[int'(m_pc >> 2)];
    return 32'h0;
  endfunction

  function automatic logic m_jump();
`ifdef FETCH_EARLY_JUMP_EN
    return m_valid && (m_ir[31:26] == 6'd2) && !PCSrc && !Stall;
`else
    return 1'b0;
`endif
  endfunction

  // One clock edge of the architectural rules, using the pre-edge memory for the fetch.
  task automatic model_edge();
    logic [31:0] inst;
    logic        jt;
    inst = m_fetch();
    jt   = m_jump();
    if (LoadEn && LoadAddr < MEM_BYTES) mmem[int'(LoadAddr >> 2)] = LoadData;
    if (Rst) begin
      m_reset();
    end else if (PCSrc) begin
      m_pc = BranchTarget & 32'hFFFF_FFFC;
      m_ifpc = 32'h0; m_ir = 32'h0; m_valid = 1'b0;
    end else if (Stall) begin
      m_valid = m_valid;
    end else if (jt) begin
      m_pc = {m_ifpc[31:28], m_ir[25:0], 2'b00};
      m_ifpc = 32'h0; m_ir = 32'h0; m_valid = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
      m_ifpc = m_pc; m_ir = inst; m_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
  endtask

  always @(negedge Clk) begin
    check("pc", PC, m_pc);
    check("ifidpc", IFIDPC, m_ifpc);
    check("ifidir", IFIDIR, m_ir);
    check("ifidvalid", 32'(IFIDValid), 32'(m_valid));
`ifdef FETCH_EARLY_JUMP_EN
    check("jumptaken", 32'(JumpTaken), 32'(m_jump()));
`endif
  end

  initial begin
    foreach (mmem[i]) mmem[i] = 32'h0;
    m_reset();
    load(32'h0,  32'h20080005);
    load(32'h4,  32'h20090007);
    load(32'h8,  32'h01095020);
    load(32'hC,  32'h0);
    load(32'h40, 32'hAC0B0010);
    check("rst_pc", PC, 32'h0);
    check("rst_valid", 32'(IFIDValid), 32'h0);

    Rst = 1'b0;
    tick();
    check("seq1_ir", IFIDIR, 32'h20080005);
    check("seq1_ifpc", IFIDPC, 32'h4);
    check("seq1_pc", PC, 32'h4);
    tick();
    check("seq2_ir", IFIDIR, 32'h20090007);

    Stall = 1'b1;
    tick(); tick();
    check("stall_pc", PC, 32'h8);
    check("stall_ir", IFIDIR, 32'h20090007);
    check("stall_ifpc", IFIDPC, 32'h8);
    Stall = 1'b0;
    tick();
    check("unstall_ir", IFIDIR, 32'h01095020);
    check("unstall_pc", PC, 32'hC);
    check("unstall_ifpc", IFIDPC, 32'hC);
    check("unstall_valid", 32'(IFIDValid), 32'h1);
    tick();

    PCSrc = 1'b1; BranchTarget = 32'h40;
    tick();
    check("br_pc", PC, 32'h40);
    check("br_ir", IFIDIR, 32'h0);
    check("br_valid", 32'(IFIDValid), 32'h0);
    PCSrc = 1'b0;
    tick();
    check("br_next_ir", IFIDIR, 32'hAC0B0010);
    check("br_next_ifpc", IFIDPC, 32'h44);

    PCSrc = 1'b1; Stall = 1'b1; BranchTarget = 32'h13;
    tick();
    check("brstall_pc", PC, 32'h10);
    check("brstall_valid", 32'(IFIDValid), 32'h0);
    PCSrc = 1'b0; Stall = 1'b0;
    tick();
    check("unloaded_ir", IFIDIR, 32'h0);
    check("unloaded_valid", 32'(IFIDValid), 32'h1);

    PCSrc = 1'b1; BranchTarget = 32'h40;
    tick();
    PCSrc = 1'b0;
    tick();
    check("pre_arst_pc", PC, 32'h44);
    Rst = 1'b1;
    m_reset();
    #1;
    check("arst_pc", PC, 32'h0);
    check("arst_ir", IFIDIR, 32'h0);
    check("arst_valid", 32'(IFIDValid), 32'h0);
    Rst = 1'b0;
    tick();
    check("post_arst_ir", IFIDIR, 32'h20080005);

    PCSrc = 1'b1; BranchTarget = 32'h400;
    tick();
    PCSrc = 1'b0;
    tick();
    check("oor_ir", IFIDIR, 32'h0);
    check("oor_ifpc", IFIDPC, 32'h404);

    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick();
    PCSrc = 1'b0;
    tick();
    check("wrap_pc", PC, 32'h0);
    check("wrap_ifpc", IFIDPC, 32'h0);
    tick();
    check("wrap_next_ir", IFIDIR, 32'h20080005);

    Stall = 1'b1; LoadEn = 1'b1; LoadAddr = 32'h4; LoadData = 32'h1234_5678;
    tick();
    LoadEn = 1'b0; Stall = 1'b0;
    check("ld_stall_ir", IFIDIR, 32'h20080005);
    tick();
    check("ld_visible_ir", IFIDIR, 32'h1234_5678);
    LoadEn = 1'b1; LoadAddr = 32'hB; LoadData = 32'hCAFE_0001;
    tick();
    LoadEn = 1'b0;
    check("ld_same_edge_ir", IFIDIR, 32'h01095020);
    LoadEn = 1'b1; LoadAddr = 32'h400; LoadData = 32'hDEAD_BEEF;
    tick();
    LoadEn = 1'b0;
    PCSrc = 1'b1; BranchTarget = 32'h8;
    tick();
    PCSrc = 1'b0;
    tick();
    check("ld_byteaddr_ir", IFIDIR, 32'hCAFE_0001);
    PCSrc = 1'b1; BranchTarget = 32'h0;
    tick();
    PCSrc = 1'b0;
    tick();
    check("ld_dropped_ir", IFIDIR, 32'h20080005);

`ifdef FETCH_EARLY_JUMP_EN
    Rst = 1'b1;
    m_reset();
    load(32'h4, 32'h0800_0010);
    Rst = 1'b0;
    tick();
    tick();
    check("j_in_ifid", IFIDIR, 32'h0800_0010);
    #1;
    check("j_taken", 32'(JumpTaken), 32'h1);
    tick();
    check("j_pc", PC, 32'h40);
    check("j_ir", IFIDIR, 32'h0);
    check("j_valid", 32'(IFIDValid), 32'h0);
    tick();
    check("j_target_ir", IFIDIR, 32'hAC0B0010);
    check("j_target_ifpc", IFIDPC, 32'h44);
`endif

    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of Decode.
- Holds the PC and a word-addressed instruction memory that the bench can load.
- Owns the IF/ID pipeline register (PC+4, instruction, valid).
- Accepts hazard stall, branch-redirect and flush controls from Decode/hazard logic and presents a stable IF/ID pair to Decode.

Parameters:
- MEM_WORDS, 256, instruction memory depth in 32-bit words (power of two).
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- Clk  input  1  pipeline clock, all state updates on posedge.
- Rst  input  1  asynchronous active-high reset.
- Stall  input  1  load-use hazard; hold PC and IF/ID.
- PCSrc  input  1  branch taken in ID; redirect PC and flush IF/ID.
- BranchTarget  input  32  redirect address used when PCSrc=1.
- LoadEn  input  1  instruction memory write strobe (bench loading).
- LoadAddr  input  32  byte address for load; bits [1:0] ignored.
- LoadData  input  32  word to store.
- PC  output  32  current fetch address.
- IFIDPC  output  32  registered PC+4 of the instruction in IF/ID.
- IFIDIR  output  32  registered instruction (0 = nop).
- IFIDValid  output  1  IF/ID holds a real fetched instruction.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): PC=RESET_PC, IFIDPC=0, IFIDIR=0, IFIDValid=0. Memory contents are not cleared. First valid IF/ID appears one posedge after Rst deasserts.
- Fetch is combinational: Inst = IMem[PC[log2(MEM_WORDS)+1:2]]. If PC >= 4*MEM_WORDS, Inst=0. PC[1:0] are ignored. Latency: instruction at PC is in IFIDIR after 1 posedge.
- PCPlus4 = PC+4, 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Per-posedge priority (highest first):
  - PCSrc=1: PC<=BranchTarget; IFIDIR<=0, IFIDPC<=0, IFIDValid<=0. Overrides Stall.
  - Stall=1: PC, IFIDPC, IFIDIR, IFIDValid all hold.
  - Otherwise: PC<=PCPlus4; IFIDPC<=PCPlus4; IFIDIR<=Inst; IFIDValid<=1.
- Load port:
  - LoadEn=1 writes LoadData to IMem[LoadAddr word index] on posedge; out-of-range addresses are dropped.
  - A write to the word currently addressed by PC is visible to the fetch on the following cycle, not the same edge.
  - Loading is independent of Stall/PCSrc.
- BranchTarget bits [1:0] are forced to 0 when loaded into PC.
- No X propagation: unloaded memory words read as 0 (initialised to 0 at time zero).

Optional Feature:
- Macro: FETCH_EARLY_JUMP_EN.
- Defined:
  - Stage pre-decodes IFIDIR.
  - If IFIDValid=1 and IFIDIR[31:26]=6'b000010 (J) and PCSrc=0 and Stall=0, then on posedge: PC<={IFIDPC[31:28],IFIDIR[25:0],2'b00}, IFIDIR<=0, IFIDValid<=0. This squashes the sequential fetch, costing one bubble.
  - PCSrc still has higher priority than the jump; Stall holds the jump pending.
  - Extra output JumpTaken (1 bit) pulses combinationally while the redirect condition is true.
- Undefined: no pre-decode. J passes through IF/ID like any other instruction; JumpTaken is absent.

Test Plan:
- Reset/sequential: load words 0..3 = 32'h20080005, 32'h20090007, 32'h01095020, 0; release Rst -> after 1st posedge IFIDIR=32'h20080005, IFIDPC=4, PC=4; after 3rd posedge IFIDIR=32'h01095020, IFIDPC=12, IFIDValid=1.
- Stall: assert Stall for 2 cycles with PC=8 -> PC stays 8, IFIDIR stays 32'h20090007, IFIDPC stays 8; on release, next edge gives IFIDIR=32'h01095020, PC=12.
- Branch flush: PCSrc=1, BranchTarget=32'h40 at PC=8 -> next edge PC=32'h40, IFIDIR=0, IFIDValid=0; following edge IFIDIR=IMem[16], IFIDPC=32'h44.
- PCSrc with Stall simultaneously, BranchTarget=32'h13 -> redirect wins: PC=32'h10, IF/ID flushed.
- Async reset mid-stream: pulse Rst between edges while PC=32'h44 -> PC=RESET_PC, IFIDIR=0, IFIDValid=0 immediately, without waiting for a clock; out-of-range PC (e.g. 32'h400 with MEM_WORDS=256) fetches 0.
- FETCH_EARLY_JUMP_EN: word 1 = 32'h08000010 -> edge after it enters IF/ID, PC=32'h40, IFIDIR=0, JumpTaken was 1; next edge IFIDIR=IMem[16].
